// File: rtl/e_mdu_controller.sv
// E-stage multiply/divide sequencer: owns HI/LO, runs the busy counter and raises the D-stage stall.
// Define MDU_MADD_EN to accept MADD/MADDU (ops 9/10); otherwise they are treated as no-ops.
module e_mdu_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        E_start,
  input  logic [3:0]  E_MDUop,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_MDUuse,
  output logic        busy,
  output logic        MDU_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] E_MDUout
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [31:0] count;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic [3:0]  op_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic        div_ovf;
  logic [63:0] result;

  function automatic logic is_mul(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MADDU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Result of the latched op; only consumed on the final busy edge.
  always_comb begin
    prod_s  = $signed({{32{rs_q[31]}}, rs_q}) * $signed({{32{rt_q[31]}}, rt_q});
    prod_u  = {32'd0, rs_q} * {32'd0, rt_q};
    div_ovf = (rs_q == 32'h8000_0000) && (rt_q == 32'hFFFF_FFFF);
    quo_s   = 32'd0;
    rem_s   = 32'd0;
    quo_u   = 32'd0;
    rem_u   = 32'd0;
    // The most-negative / -1 case overflows a 32-bit signed divide, so it is pinned explicitly.
    if (div_ovf) begin
      quo_s = 32'h8000_0000;
    end else if (rt_q != 32'd0) begin
      quo_s = $signed(rs_q) / $signed(rt_q);
      rem_s = $signed(rs_q) % $signed(rt_q);
    end
    if (rt_q != 32'd0) begin
      quo_u = rs_q / rt_q;
      rem_u = rs_q % rt_q;
    end
    case (op_q)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = (rt_q == 32'd0) ? {HI, LO} : {rem_s, quo_s};
      OP_DIVU:  result = (rt_q == 32'd0) ? {HI, LO} : {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {HI, LO} + prod_s;
      OP_MADDU: result = {HI, LO} + prod_u;
`endif
      default:  result = {HI, LO};
    endcase
  end

  // Sequencer: starts are only honoured in IDLE, so a start while busy is silently dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= 32'd0;
      HI    <= 32'd0;
      LO    <= 32'd0;
      rs_q  <= 32'd0;
      rt_q  <= 32'd0;
      op_q  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (E_start) begin
            if (is_mul(E_MDUop)) begin
              rs_q  <= E_rs;
              rt_q  <= E_rt;
              op_q  <= E_MDUop;
              count <= 32'(MULT_CYCLES);
              busy  <= 1'b1;
              state <= MUL;
            end else if (is_div(E_MDUop)) begin
              rs_q  <= E_rs;
              rt_q  <= E_rt;
              op_q  <= E_MDUop;
              count <= 32'(DIV_CYCLES);
              busy  <= 1'b1;
              state <= DIV;
            end else if (E_MDUop == OP_MTHI) begin
              HI <= E_rs;
            end else if (E_MDUop == OP_MTLO) begin
              LO <= E_rs;
            end
          end
        end
        default: begin
          if (count == 32'd1) begin
            {HI, LO} <= result;
            count    <= 32'd0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            count <= count - 32'd1;
          end
        end
      endcase
    end
  end

  assign MDU_stall = D_MDUuse & (busy | (E_start & (is_mul(E_MDUop) | is_div(E_MDUop))));

  always_comb begin
    case (E_MDUop)
      OP_MFHI: E_MDUout = HI;
      OP_MFLO: E_MDUout = LO;
      default: E_MDUout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_e_mdu_controller.sv
// Scoreboard bench for e_mdu_controller: stimulus pushes expected HI/LO/busy-length and MFHI/MFLO data,
// a negedge monitor pops and compares them when the DUT completes an op or presents read data.
module tb_e_mdu_controller;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;
`ifdef MDU_MADD_EN
  localparam bit MADD_EN = 1'b1;
`else
  localparam bit MADD_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        E_start;
  logic [3:0]  E_MDUop;
  logic [31:0] E_rs;
  logic [31:0] E_rt;
  logic        D_MDUuse;
  logic        busy;
  logic        MDU_stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] E_MDUout;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } res_t;

  res_t        res_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          total;
  int          bad;

  e_mdu_controller #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .E_start  (E_start),
    .E_MDUop  (E_MDUop),
    .E_rs     (E_rs),
    .E_rt     (E_rt),
    .D_MDUuse (D_MDUuse),
    .busy     (busy),
    .MDU_stall(MDU_stall),
    .HI       (HI),
    .LO       (LO),
    .E_MDUout (E_MDUout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Architectural result computed with 64-bit integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] hi,
                                             input logic [31:0] lo);
    longint      a;
    longint      b;
    longint      q;
    longint      r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] uq;
    logic [63:0] ur;
    a  = longint'($signed(rs));
    b  = longint'($signed(rt));
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      4'd1: return 64'(a * b);
      4'd2: return ua * ub;
      4'd3: begin
        if (rt == 32'd0) return {hi, lo};
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (rt == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd9:  return {hi, lo} + 64'(a * b);
      4'd10: return {hi, lo} + (ua * ub);
      default: return {hi, lo};
    endcase
  endfunction

  // Issues one op, records its expected outcome and returns once the DUT can accept the next op.
  task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    logic        md;
    int          len;
    logic [63:0] exp;
    md  = ((op >= 4'd1) && (op <= 4'd4)) || (MADD_EN && ((op == 4'd9) || (op == 4'd10)));
    len = ((op == 4'd3) || (op == 4'd4)) ? DIV_CYCLES : MULT_CYCLES;
    E_start = 1'b1;
    E_MDUop = op;
    E_rs    = rs;
    E_rt    = rt;
    if (md) begin
      exp = ref_result(op, rs, rt, m_hi, m_lo);
      res_q.push_back('{exp[63:32], exp[31:0], len});
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end else if (op == 4'd5) begin
      m_hi = rs;
    end else if (op == 4'd6) begin
      m_lo = rs;
    end else if (op == 4'd7) begin
      rd_q.push_back(m_hi);
    end else if (op == 4'd8) begin
      rd_q.push_back(m_lo);
    end
    D_MDUuse = 1'b1;
    #1;
    check_output("stall_issue", {63'd0, MDU_stall}, {63'd0, md});
    D_MDUuse = 1'b0;
    @(posedge clk);
    #1;
    E_start  = 1'b0;
    E_MDUop  = 4'd0;
    D_MDUuse = 1'b1;
    #1;
    check_output("stall_busy", {63'd0, MDU_stall}, {63'd0, md});
    D_MDUuse = 1'b0;
    #1;
    check_output("stall_nouse", {63'd0, MDU_stall}, 64'd0);
    if (md) begin
      repeat (len) @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pops expectations on busy falling and on MFHI/MFLO issue.
  initial begin
    logic prev;
    int   cnt;
    res_t e;
    prev = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        cnt  = 0;
      end else begin
        if (E_start) begin
          check_output("issue_while_busy", {63'd0, busy}, 64'd0);
          if ((E_MDUop == 4'd7) || (E_MDUop == 4'd8)) begin
            if (rd_q.size() == 0) begin
              check_output("unexpected_read", 64'd1, 64'd0);
            end else begin
              check_output("mdu_out", {32'd0, E_MDUout}, {32'd0, rd_q.pop_front()});
            end
          end
        end
        if (busy) begin
          cnt++;
        end else if (prev) begin
          if (res_q.size() == 0) begin
            check_output("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = res_q.pop_front();
            check_output("hi", {32'd0, HI}, {32'd0, e.hi});
            check_output("lo", {32'd0, LO}, {32'd0, e.lo});
            check_output("busy_len", 64'(cnt), 64'(e.len));
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    total    = 0;
    bad      = 0;
    m_hi     = 32'd0;
    m_lo     = 32'd0;
    reset_n  = 1'b0;
    E_start  = 1'b0;
    E_MDUop  = 4'd7;
    E_rs     = 32'd0;
    E_rt     = 32'd0;
    D_MDUuse = 1'b1;
    #2;
    check_output("rst_busy", {63'd0, busy}, 64'd0);
    check_output("rst_hi", {32'd0, HI}, 64'd0);
    check_output("rst_lo", {32'd0, LO}, 64'd0);
    check_output("rst_stall", {63'd0, MDU_stall}, 64'd0);
    check_output("rst_mdu_out", {32'd0, E_MDUout}, 64'd0);
    E_MDUop  = 4'd0;
    D_MDUuse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    apply_stimulus(4'd1, 32'hFFFF_FFFE, 32'd3);
    check_output("mult_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    check_output("mult_lo", {32'd0, LO}, 64'hFFFF_FFFA);
    apply_stimulus(4'd2, 32'hFFFF_FFFE, 32'd3);
    check_output("multu_hi", {32'd0, HI}, 64'h2);
    check_output("multu_lo", {32'd0, LO}, 64'hFFFF_FFFA);
    apply_stimulus(4'd3, 32'hFFFF_FFF9, 32'd2);
    check_output("div_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    check_output("div_lo", {32'd0, LO}, 64'hFFFF_FFFD);
    apply_stimulus(4'd3, 32'd12345, 32'd0);
    check_output("div0_hi", {32'd0, HI}, 64'hFFFF_FFFF);
    check_output("div0_lo", {32'd0, LO}, 64'hFFFF_FFFD);
    apply_stimulus(4'd6, 32'h0000_1234, 32'd0);
    apply_stimulus(4'd8, 32'd0, 32'd0);
    check_output("mtlo_lo", {32'd0, LO}, 64'h1234);
    apply_stimulus(4'd1, 32'd7, 32'd6);
    apply_stimulus(4'd3, 32'd100, 32'd7);
    check_output("b2b_hi", {32'd0, HI}, 64'd2);
    check_output("b2b_lo", {32'd0, LO}, 64'd14);
    apply_stimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check_output("ovf_hi", {32'd0, HI}, 64'd0);
    check_output("ovf_lo", {32'd0, LO}, 64'h8000_0000);
    apply_stimulus(4'd5, 32'd0, 32'd0);
    apply_stimulus(4'd6, 32'hFFFF_FFFF, 32'd0);
    apply_stimulus(4'd10, 32'd1, 32'd1);
    check_output("maddu_hi", {32'd0, HI}, MADD_EN ? 64'd1 : 64'd0);
    check_output("maddu_lo", {32'd0, LO}, MADD_EN ? 64'd0 : 64'hFFFF_FFFF);

    // Reset in the fourth busy cycle of a DIV must abort it with no late write.
    apply_stimulus(4'd5, 32'hAAAA_AAAA, 32'd0);
    apply_stimulus(4'd6, 32'h5555_5555, 32'd0);
    E_start = 1'b1;
    E_MDUop = 4'd3;
    E_rs    = 32'd100;
    E_rt    = 32'd3;
    @(posedge clk);
    #1;
    E_start = 1'b0;
    E_MDUop = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    m_hi    = 32'd0;
    m_lo    = 32'd0;
    #1;
    check_output("abort_busy", {63'd0, busy}, 64'd0);
    check_output("abort_hi", {32'd0, HI}, 64'd0);
    check_output("abort_lo", {32'd0, LO}, 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_output("abort_late_hi", {32'd0, HI}, 64'd0);
    check_output("abort_late_lo", {32'd0, LO}, 64'd0);
    check_output("abort_late_busy", {63'd0, busy}, 64'd0);

    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      rs = $urandom;
      rt = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 4) == 0) rs = 32'h8000_0000;
      if ($urandom_range(0, 4) == 0) rt = 32'hFFFF_FFFF;
      apply_stimulus(op, rs, rt);
      if ($urandom_range(0, 1) == 1) begin
        apply_stimulus(4'd7, 32'd0, 32'd0);
        apply_stimulus(4'd8, 32'd0, 32'd0);
      end
    end

    for (int i = 0; i < 50 && (res_q.size() != 0 || rd_q.size() != 0); i++) @(posedge clk);
    check_output("drain_res", 64'(res_q.size()), 64'd0);
    check_output("drain_rd", 64'(rd_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
